apb_req_arbiter: RTL and testbench
==================================

// Module: apb_req_arbiter
// PURPOSE
//  Two-requester APB master front end: arbitrates between requester ports 0/1 (round-robin), runs the APB
//  IDLE->SETUP->ACCESS sequence on the shared bus, decodes one of two slave selects from the address and
//  returns read data and error to the granted requester. Bounds pready wait with a timeout.
//  Sits between the system-side requesters and the APB bridge/slave bus.
// PARAMETERS
//  D_WIDTH   32  address and data width (matches `D_WIDTH)
//  SEL_BIT   31  address bit decoding the slave: 0 -> psel[0], 1 -> psel[1]
//  TIMEOUT   16  max ACCESS cycles with pready low before forced error completion (>=1)
// PORTS
//  pclk        in   1          APB clock, all logic on rising edge
//  presetn     in   1          asynchronous active-low reset
//  req_valid   in   2          per-requester request; held with fields stable until its req_done
//  req_addr    in   2*D_WIDTH  {addr1,addr0}
//  req_write   in   2          1=write, 0=read
//  req_wdata   in   2*D_WIDTH  {wdata1,wdata0}
//  req_strb    in   8          {strb1,strb0}, 4 byte strobes each
//  req_prot    in   6          {prot1,prot0}, 3 bits each
//  req_done    out  2          one-cycle completion pulse to the granted requester
//  rsp_rdata   out  D_WIDTH    read data, valid with req_done
//  rsp_err     out  1          pslverr or timeout, valid with req_done
//  psel        out  2          slave selects, at most one high
//  penable     out  1          APB enable
//  paddr       out  D_WIDTH    APB address
//  pwrite      out  1          APB direction
//  pwdata      out  D_WIDTH    APB write data
//  pstrb       out  4          APB write strobes (forced 0 on reads)
//  pprot       out  3          APB protection
//  pready      in   1          slave ready
//  prdata      in   D_WIDTH    slave read data
//  pslverr     in   1          slave error
// BEHAVIOUR
//  - Reset (presetn low, async): state=IDLE, all outputs 0, grant pointer last=1 (req 0 wins first), timeout
//    counter 0. Reset mid-transfer aborts it immediately; no req_done is issued for the aborted request.
//  - All APB outputs, req_done, rsp_* are registered.
//  - IDLE: psel=0, penable=0. If any req_valid: pick winner; if both, winner = requester != last; last<=winner.
//    Latch winner's addr/write/wdata/strb/prot onto APB outputs, psel[addr[SEL_BIT]]=1 -> SETUP.
//  - SETUP (one cycle): psel held, penable=0 -> ACCESS with penable=1, counter cleared.
//  - ACCESS: outputs held stable. pready=1: next cycle req_done[winner]=1, rsp_rdata=prdata (reads; 0 on
//    writes), rsp_err=pslverr; psel/penable drop; state -> IDLE. pready=0: counter+1; when counter reaches
//    TIMEOUT: complete as above with rsp_err=1, rsp_rdata=0.
//  - Minimum latency: req_valid sampled in IDLE at edge N -> SETUP N+1, ACCESS N+2, req_done N+3 when
//    pready=1 at first ACCESS cycle. One transfer = 3 cycles + wait states; one IDLE cycle between transfers.
//  - req_done is a single-cycle pulse; rsp_rdata/rsp_err hold until next completion.
//  - req_valid dropped by a requester before its grant: ignored. Dropped after grant: transfer still completes.
//  - Winner's request is re-evaluated in IDLE after req_done; requester must drop req_valid on req_done or
//    it is treated as a new request.
//  - Both requests held continuously: strict alternation 0,1,0,1...
//  - pready/pslverr/prdata ignored outside ACCESS. psel never has both bits high.
// TESTING
//  - Single read req0 addr 0x0000_0010, pready=1 immediately, prdata=0xDEAD_BEEF -> psel=01 N+1,
//    penable N+2, req_done[0] N+3, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
//  - Write req1 addr 0x8000_0004, wdata 0x1234_5678, strb 4'b0011, 2 wait states -> psel=10,
//    pstrb=0011, pwdata stable through ACCESS, req_done[1] at N+5, rsp_err=0.
//  - Both req_valid held for 4 transfers from reset -> grant order 0,1,0,1, one req_done per transfer.
//  - pready held 0, TIMEOUT=16 -> req_done with rsp_err=1, rsp_rdata=0 after 16 ACCESS cycles; bus idle.
//  - pslverr=1 with pready on a read -> rsp_err=1, rsp_rdata=prdata.
//  - presetn low during ACCESS -> all outputs 0 same cycle, no req_done; after release req0 granted first.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Two-requester APB master front end: round-robin grant, IDLE/SETUP/ACCESS bus
// sequencing, address-decoded slave select and a bounded pready wait.
module apb_req_arbiter #(
  parameter int D_WIDTH = 32,
  parameter int SEL_BIT = 31,
  parameter int TIMEOUT = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic [1:0]           req_valid,
  input  logic [2*D_WIDTH-1:0] req_addr,
  input  logic [1:0]           req_write,
  input  logic [2*D_WIDTH-1:0] req_wdata,
  input  logic [7:0]           req_strb,
  input  logic [5:0]           req_prot,
  output logic [1:0]           req_done,
  output logic [D_WIDTH-1:0]   rsp_rdata,
  output logic                 rsp_err,
  output logic [1:0]           psel,
  output logic                 penable,
  output logic [D_WIDTH-1:0]   paddr,
  output logic                 pwrite,
  output logic [D_WIDTH-1:0]   pwdata,
  output logic [3:0]           pstrb,
  output logic [2:0]           pprot,
  input  logic                 pready,
  input  logic [D_WIDTH-1:0]   prdata,
  input  logic                 pslverr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state;
  logic               last;
  logic               win;
  logic [CW-1:0]      cnt;

  logic               nxt_win;
  logic [D_WIDTH-1:0] sel_addr;
  logic [D_WIDTH-1:0] sel_wdata;
  logic               sel_write;
  logic [3:0]         sel_strb;
  logic [2:0]         sel_prot;

  // Contention goes to the requester not served last; otherwise the lone requester wins.
  always_comb begin
    nxt_win   = (&req_valid) ? ~last : req_valid[1];
    sel_addr  = nxt_win ? req_addr[2*D_WIDTH-1:D_WIDTH]  : req_addr[D_WIDTH-1:0];
    sel_wdata = nxt_win ? req_wdata[2*D_WIDTH-1:D_WIDTH] : req_wdata[D_WIDTH-1:0];
    sel_write = nxt_win ? req_write[1] : req_write[0];
    sel_strb  = nxt_win ? req_strb[7:4] : req_strb[3:0];
    sel_prot  = nxt_win ? req_prot[5:3] : req_prot[2:0];
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      last      <= 1'b1;
      win       <= 1'b0;
      cnt       <= '0;
      req_done  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= '0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
    end else begin
      req_done <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            win    <= nxt_win;
            last   <= nxt_win;
            paddr  <= sel_addr;
            pwrite <= sel_write;
            pwdata <= sel_wdata;
            pstrb  <= sel_write ? sel_strb : '0;
            pprot  <= sel_prot;
            psel   <= sel_addr[SEL_BIT] ? 2'b10 : 2'b01;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          // cnt counts wait cycles already spent; the TIMEOUT-th low-pready cycle completes with error.
          if (pready || cnt == CW'(TIMEOUT - 1)) begin
            req_done  <= win ? 2'b10 : 2'b01;
            rsp_err   <= pready ? pslverr : 1'b1;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
            psel      <= '0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_apb_req_arbiter;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic [1:0]    req_valid = '0;
  logic [2*DW-1:0] req_addr = '0;
  logic [1:0]    req_write = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [7:0]    req_strb = '0;
  logic [5:0]    req_prot = '0;
  logic [1:0]    req_done;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [1:0]    psel;
  logic          penable;
  logic [DW-1:0] paddr;
  logic          pwrite;
  logic [DW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic [2:0]    pprot;
  logic          pready = 1'b0;
  logic [DW-1:0] prdata = '0;
  logic          pslverr = 1'b0;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  apb_req_arbiter #(.D_WIDTH(DW), .SEL_BIT(31), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn), .req_valid(req_valid), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel),
    .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: m_age is cycles since grant (0 = bus free,
  // 1 = setup cycle, n>=2 = (n-1)-th access cycle).
  int            m_age;
  logic          m_last, m_win;
  logic          m_pick;
  logic [1:0]    e_psel, e_done;
  logic          e_penable, e_pwrite, e_err;
  logic [DW-1:0] e_paddr, e_pwdata, e_rdata;
  logic [3:0]    e_pstrb;
  logic [2:0]    e_pprot;

  assign m_pick = (req_valid == 2'b11) ? ~m_last : req_valid[1];

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      m_age <= 0; m_last <= 1'b1; m_win <= 1'b0;
      e_psel <= '0; e_done <= '0; e_penable <= 1'b0; e_pwrite <= 1'b0; e_err <= 1'b0;
      e_paddr <= '0; e_pwdata <= '0; e_rdata <= '0; e_pstrb <= '0; e_pprot <= '0;
    end else begin
      e_done <= '0;
      if (m_age == 0) begin
        if (req_valid != 2'b00) begin
          m_win    <= m_pick;
          m_last   <= m_pick;
          e_paddr  <= req_addr[m_pick*DW +: DW];
          e_pwdata <= req_wdata[m_pick*DW +: DW];
          e_pwrite <= req_write[m_pick];
          e_pstrb  <= req_write[m_pick] ? req_strb[m_pick*4 +: 4] : 4'h0;
          e_pprot  <= req_prot[m_pick*3 +: 3];
          e_psel   <= 2'b01 << req_addr[m_pick*DW + 31];
          m_age    <= 1;
        end
      end else if (m_age == 1) begin
        e_penable <= 1'b1;
        m_age     <= 2;
      end else if (pready || (m_age - 1) == TMO) begin
        e_done    <= 2'b01 << m_win;
        e_err     <= pready ? pslverr : 1'b1;
        e_rdata   <= (pready && !e_pwrite) ? prdata : '0;
        e_psel    <= '0;
        e_penable <= 1'b0;
        m_age     <= 0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge pclk) begin
    if (chk_en) begin
      check("psel", 64'(psel), 64'(e_psel));
      check("penable", 64'(penable), 64'(e_penable));
      check("req_done", 64'(req_done), 64'(e_done));
      check("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
      check("rsp_err", 64'(rsp_err), 64'(e_err));
      check("paddr", 64'(paddr), 64'(e_paddr));
      check("pwrite", 64'(pwrite), 64'(e_pwrite));
      check("pwdata", 64'(pwdata), 64'(e_pwdata));
      check("pstrb", 64'(pstrb), 64'(e_pstrb));
      check("pprot", 64'(pprot), 64'(e_pprot));
    end
  end

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic w,
                         input logic [31:0] d, input logic [3:0] s, input logic [2:0] p);
    req_addr[i*DW +: DW]  = a;
    req_write[i]          = w;
    req_wdata[i*DW +: DW] = d;
    req_strb[i*4 +: 4]    = s;
    req_prot[i*3 +: 3]    = p;
    req_valid[i]          = 1'b1;
  endtask

  logic [1:0] order[$];

  initial begin
    chk_en = 1'b1;
    ticks(2);
    check("reset_psel", 64'(psel), 64'h0);
    check("reset_done", 64'(req_done), 64'h0);
    check("reset_paddr", 64'(paddr), 64'h0);
    presetn = 1'b1;
    ticks(2);

    // Single read, zero wait states
    set_req(0, 32'h0000_0010, 1'b0, 32'h0, 4'hF, 3'd2);
    pready = 1'b1; prdata = 32'hDEAD_BEEF;
    tick();
    check("t1_psel", 64'(psel), 64'h1);
    check("t1_pen_setup", 64'(penable), 64'h0);
    check("t1_pstrb_read", 64'(pstrb), 64'h0);
    req_valid = '0;
    tick();
    check("t1_pen_access", 64'(penable), 64'h1);
    tick();
    check("t1_done", 64'(req_done), 64'h1);
    check("t1_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    check("t1_err", 64'(rsp_err), 64'h0);
    tick();
    check("t1_done_pulse", 64'(req_done), 64'h0);

    // Write with two wait states
    pready = 1'b0;
    set_req(1, 32'h8000_0004, 1'b1, 32'h1234_5678, 4'b0011, 3'd1);
    tick();
    check("t2_psel", 64'(psel), 64'h2);
    check("t2_pstrb", 64'(pstrb), 64'h3);
    req_valid = '0;
    ticks(2);
    check("t2_pwdata", 64'(pwdata), 64'h1234_5678);
    tick();
    check("t2_no_done", 64'(req_done), 64'h0);
    pready = 1'b1;
    tick();
    check("t2_done", 64'(req_done), 64'h2);
    check("t2_err", 64'(rsp_err), 64'h0);
    check("t2_rdata", 64'(rsp_rdata), 64'h0);

    // Both requesters held from reset: strict alternation
    presetn = 1'b0;
    set_req(0, 32'h0000_0100, 1'b0, 32'h0, 4'h0, 3'd0);
    set_req(1, 32'h8000_0200, 1'b0, 32'h0, 4'h0, 3'd0);
    tick();
    presetn = 1'b1;
    order.delete();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (req_done != 2'b00) order.push_back(req_done);
    end
    req_valid = '0;
    check("t3_count", 64'(order.size()), 64'd4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      check("t3_order", 64'(order[i]), (i % 2 == 0) ? 64'h1 : 64'h2);
    ticks(2);

    // Timeout with pready stuck low
    pready = 1'b0; prdata = 32'h0000_0055;
    set_req(0, 32'h0000_0020, 1'b0, 32'h0, 4'h0, 3'd0);
    tick();
    req_valid = '0;
    ticks(16);
    check("t4_not_yet", 64'(req_done), 64'h0);
    check("t4_pen", 64'(penable), 64'h1);
    tick();
    check("t4_done", 64'(req_done), 64'h1);
    check("t4_err", 64'(rsp_err), 64'h1);
    check("t4_rdata", 64'(rsp_rdata), 64'h0);
    check("t4_idle", 64'(psel), 64'h0);

    // Slave error on a read still returns prdata
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hA5A5_0001;
    set_req(1, 32'h8000_0008, 1'b0, 32'h0, 4'h0, 3'd5);
    tick();
    req_valid = '0;
    ticks(2);
    check("t5_done", 64'(req_done), 64'h2);
    check("t5_err", 64'(rsp_err), 64'h1);
    check("t5_rdata", 64'(rsp_rdata), 64'hA5A5_0001);
    pslverr = 1'b0;
    tick();

    // Reset in ACCESS aborts; req0 wins first afterwards
    pready = 1'b0;
    set_req(1, 32'h0000_0300, 1'b1, 32'h1111_2222, 4'hF, 3'd0);
    tick();
    set_req(0, 32'h8000_0400, 1'b0, 32'h0, 4'h0, 3'd0);
    ticks(2);
    check("t6_in_access", 64'(penable), 64'h1);
    #2 presetn = 1'b0;
    #1;
    check("t6_rst_psel", 64'(psel), 64'h0);
    check("t6_rst_pen", 64'(penable), 64'h0);
    check("t6_rst_paddr", 64'(paddr), 64'h0);
    check("t6_rst_rdata", 64'(rsp_rdata), 64'h0);
    ticks(2);
    check("t6_no_done", 64'(req_done), 64'h0);
    presetn = 1'b1;
    tick();
    check("t6_req0_first", 64'(psel), 64'h2);
    req_valid = '0;
    pready = 1'b1;
    ticks(2);
    check("t6_done", 64'(req_done), 64'h1);
    tick();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      pready  = ($urandom_range(0, 7) < 5);
      pslverr = ($urandom_range(0, 3) == 0);
      prdata  = $urandom;
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && e_done[i])
          req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(0, 31) == 0)
          req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, $urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom));
      end
      if (c % 100 == 0) pready = ($urandom_range(0, 3) != 0) && (c % 700 != 0);
      tick();
    end
    req_valid = '0;
    pready = 1'b1;
    ticks(25);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
